// File: rtl/counter_arbiter_if.sv
// Requester-side bus of the shared interval counter: request levels and lengths in,
// grant, completion and counter status out.
interface counter_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int OWW   = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [OWW-1:0]        owner;
    logic [WIDTH-1:0]      cnt;

    modport master (output req, len, input gnt, done, busy, owner, cnt);
    modport slave  (input req, len, output gnt, done, busy, owner, cnt);
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin scheduler that lends one WIDTH-bit interval counter to NREQ requesters.
//   state  | meaning
//   IDLE   | no owner; arbitrate over req starting at ptr
//   RUN    | owner holds gnt, cnt counts 0..len_q-1
//   DONE   | done pulse to owner; ptr advances past owner
module counter_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int OWW   = 2
) (
    input  logic                 clk2,
    input  logic                 rstn,
    counter_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [OWW-1:0]   ptr_q, ptr_d;
    logic [OWW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] len_q, len_d;

    logic [OWW-1:0]   win;
    logic [OWW-1:0]   cand;
    logic             found;
    logic [WIDTH-1:0] len_sel;
    logic [WIDTH-1:0] term;
    logic [OWW-1:0]   owner_nxt;

    // First pending request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            cand = OWW'((int'(ptr_q) + off) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        len_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == OWW'(i)) len_sel = bus.len[i*WIDTH +: WIDTH];
        end
    end

    // len_q of zero wraps to all-ones, giving a full 2**WIDTH cycle interval.
    assign term      = len_q - 1'b1;
    assign owner_nxt = (owner_q == OWW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (found) begin
                    owner_d = win;
                    gnt_d   = NREQ'(1) << win;
                    len_d   = len_sel;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!bus.req[owner_q]) begin
                    gnt_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = owner_nxt;
                    state_d = S_IDLE;
                end else if (cnt_q == term) begin
                    gnt_d           = '0;
                    cnt_d           = '0;
                    done_d[owner_q] = 1'b1;
                    state_d         = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                ptr_d   = owner_nxt;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk2) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.owner = owner_q;
    assign bus.cnt   = cnt_q;
endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against an interval-level reference model.
module tb_counter_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int OWW   = 2;
    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;

    logic clk2 = 1'b0;
    logic rstn = 1'b0;

    counter_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .OWW(OWW)) bus ();

    counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .OWW(OWW)) dut (
        .clk2 (clk2),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk2 = ~clk2;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: which phase, who owns the counter, how long the interval is,
    // how many cycles of it have elapsed, and where the search starts next.
    int m_phase   = PH_IDLE;
    int m_owner   = 0;
    int m_ptr     = 0;
    int m_len     = 0;
    int m_elapsed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int len_of(input int i);
        int v;
        v = (int'(bus.len) >> (i * WIDTH)) & ((1 << WIDTH) - 1);
        return (v == 0) ? (1 << WIDTH) : v;
    endfunction

    task automatic model_step();
        bit got;
        if (!rstn) begin
            m_phase = PH_IDLE; m_owner = 0; m_ptr = 0; m_len = 0; m_elapsed = 0;
        end else begin
            case (m_phase)
                PH_IDLE: begin
                    got = 1'b0;
                    for (int k = 0; k < NREQ; k++) begin
                        if (!got && bus.req[(m_ptr + k) % NREQ]) begin
                            got     = 1'b1;
                            m_owner = (m_ptr + k) % NREQ;
                        end
                    end
                    if (got) begin
                        m_len     = len_of(m_owner);
                        m_elapsed = 0;
                        m_phase   = PH_RUN;
                    end
                end
                PH_RUN: begin
                    if (!bus.req[m_owner]) begin
                        m_phase = PH_IDLE;
                        m_ptr   = (m_owner + 1) % NREQ;
                    end else if (m_elapsed + 1 == m_len) begin
                        m_phase = PH_DONE;
                    end else begin
                        m_elapsed++;
                    end
                end
                default: begin
                    m_phase = PH_IDLE;
                    m_ptr   = (m_owner + 1) % NREQ;
                end
            endcase
        end
    endtask

    task automatic compare_outputs();
        int e_gnt, e_done, e_cnt;
        e_gnt  = (m_phase == PH_RUN)  ? (1 << m_owner) : 0;
        e_done = (m_phase == PH_DONE) ? (1 << m_owner) : 0;
        e_cnt  = (m_phase == PH_RUN)  ? m_elapsed : 0;
        check("gnt",   32'(bus.gnt),   32'(e_gnt));
        check("done",  32'(bus.done),  32'(e_done));
        check("busy",  32'(bus.busy),  32'(m_phase != PH_IDLE));
        check("owner", 32'(bus.owner), 32'(m_owner));
        check("cnt",   32'(bus.cnt),   32'(e_cnt));
    endtask

    task automatic cyc();
        @(posedge clk2);
        #1;
        model_step();
        compare_outputs();
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        bus.req = '0;
        cyc();
        rstn = 1'b1;
    endtask

    int   order[$];
    int   ngnt;
    logic [NREQ-1:0] prev_gnt;
    logic [NREQ-1:0] seen_done;

    initial begin
        bus.req = 4'b1111;
        bus.len = 16'h1111;
        rstn    = 1'b0;

        // Reset held with every request asserted.
        repeat (3) cyc();
        check("rst_gnt",   32'(bus.gnt),   32'h0);
        check("rst_done",  32'(bus.done),  32'h0);
        check("rst_busy",  32'(bus.busy),  32'h0);
        check("rst_cnt",   32'(bus.cnt),   32'h0);
        check("rst_owner", 32'(bus.owner), 32'h0);
        rstn    = 1'b1;
        bus.req = '0;
        cyc();

        // Single request of length 3 from requester 2.
        do_reset();
        bus.len = 16'h0300;
        bus.req = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("single_gnt", 32'(bus.gnt), 32'h4);
            check("single_cnt", 32'(bus.cnt), 32'(k));
        end
        cyc();
        check("single_done", 32'(bus.done), 32'h4);
        check("single_gnt_off", 32'(bus.gnt), 32'h0);
        bus.req = '0;
        cyc();
        check("single_busy_off", 32'(bus.busy), 32'h0);
        check("single_done_off", 32'(bus.done), 32'h0);

        // Round-robin: everybody requests, each drops after its done.
        do_reset();
        bus.len  = 16'h1111;
        bus.req  = 4'b1111;
        prev_gnt = '0;
        order.delete();
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (bus.gnt != 0 && prev_gnt == 0) order.push_back(int'(bus.owner));
            prev_gnt = bus.gnt;
            if (bus.done != 0) bus.req = bus.req & ~bus.done;
            if (bus.req == 0 && !bus.busy) break;
        end
        check("rr_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size() && i < 4; i++) check("rr_order", 32'(order[i]), 32'(i));

        // Length 0 on requester 1 wraps to a full 16-cycle interval.
        do_reset();
        bus.len   = 16'h0000;
        bus.req   = 4'b0010;
        ngnt      = 0;
        seen_done = '0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (bus.gnt == 4'b0010) ngnt++;
            if (bus.done != 0) begin
                seen_done = bus.done;
                break;
            end
        end
        check("wrap_len", 32'(ngnt), 32'd16);
        check("wrap_done", 32'(seen_done), 32'h2);
        bus.req = '0;
        cyc();

        // Abort: owner 0 drops at cnt=2, pending requester 1 takes over.
        do_reset();
        bus.len = 16'h0005;
        bus.req = 4'b0011;
        repeat (3) cyc();
        check("abort_cnt2", 32'(bus.cnt), 32'd2);
        bus.req = 4'b0010;
        cyc();
        check("abort_gnt", 32'(bus.gnt), 32'h0);
        check("abort_done", 32'(bus.done), 32'h0);
        cyc();
        check("abort_next_gnt", 32'(bus.gnt), 32'h2);
        check("abort_next_owner", 32'(bus.owner), 32'd1);
        bus.req = '0;
        repeat (2) cyc();

        // Reset while requester 2 is mid-interval.
        do_reset();
        bus.len = 16'h0700;
        bus.req = 4'b0100;
        repeat (3) cyc();
        rstn = 1'b0;
        cyc();
        check("midrst_gnt",   32'(bus.gnt),   32'h0);
        check("midrst_done",  32'(bus.done),  32'h0);
        check("midrst_busy",  32'(bus.busy),  32'h0);
        check("midrst_owner", 32'(bus.owner), 32'h0);
        rstn    = 1'b1;
        bus.req = '0;
        cyc();

        // Length snapshot: changing len[3] during the run has no effect.
        do_reset();
        bus.len = 16'h4000;
        bus.req = 4'b1000;
        cyc();
        bus.len   = 16'h9000;
        ngnt      = 1;
        seen_done = '0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (bus.done != 0) begin
                seen_done = bus.done;
                break;
            end
            if (bus.gnt == 4'b1000) ngnt++;
        end
        check("snap_len", 32'(ngnt), 32'd4);
        check("snap_done", 32'(seen_done), 32'h8);
        bus.req = '0;
        cyc();

        // Random traffic with occasional resets and aborts.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.done[i]) bus.req[i] = ($urandom_range(0, 9) == 0);
                else if ($urandom_range(0, 9) == 0) bus.req[i] = ~bus.req[i];
            end
            if ($urandom_range(0, 3) == 0) bus.len = 16'($urandom);
            rstn = ($urandom_range(0, 149) != 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Round-robin scheduler that shares one WIDTH-bit interval counter among NREQ requesters. Each requester asks for a timed interval of a programmable length. The arbiter grants the counter to one requester at a time, runs the count, and signals completion with a one-cycle done pulse. It sits between the digital control logic and the shared counter resource in the mixed-signal test designs.

## Interface
- NREQ, default 4: number of requesters (2..8).
- WIDTH, default 4: counter and length width.
- OWW, default 2: width of the owner index; must satisfy 2**OWW >= NREQ.

- clk2, input, 1: clock; all state updates on its rising edge.
- rstn, input, 1: reset, synchronous, active-low. Sampled on the clk2 rising edge.
- req, input, NREQ: per-requester request level.
- len, input, NREQ*WIDTH: interval length, flattened; requester i uses len[i*WIDTH +: WIDTH].
- gnt, output, NREQ: one-hot grant, registered; high for the owner during RUN.
- done, output, NREQ: one-cycle completion pulse to the owner, registered.
- busy, output, 1: high when the state is not IDLE.
- owner, output, OWW: index of the current or last granted requester.
- cnt, output, WIDTH: shared counter value, registered.

## Operation
- States are IDLE, RUN and DONE, plus a round-robin pointer ptr (OWW bits).
- Reset (rstn=0 at an edge): state=IDLE, gnt=0, done=0, busy=0, cnt=0, owner=0, ptr=0. Reset has priority over every other event, including mid-RUN; no done pulse is issued.
- **IDLE:**
  - If req != 0, select the first set req bit searching ptr, ptr+1, …, NREQ-1, 0, … (modulo NREQ).
  - Then: owner=winner, gnt=onehot(winner), snapshot len_q=len[winner], cnt=0, go to RUN.
  - If req == 0, stay in IDLE; cnt holds 0.
- **RUN:** cnt increments by 1 each cycle, modulo 2**WIDTH. Check these in order:
  - Abort: if req[owner]=0, set gnt=0, cnt=0, ptr=owner+1 (mod NREQ) and go to IDLE. No done pulse. Abort beats terminal.
  - Terminal: when cnt == len_q-1 (mod 2**WIDTH), go to DONE, set gnt=0, cnt=0, done[owner]=1.
- **DONE:** done clears. Set ptr=owner+1 (mod NREQ) and go to IDLE.
- Interval length is len_q cycles, with cnt taking values 0..len_q-1 while gnt is high. len_q=0 means 2**WIDTH cycles (cnt 0..15 for WIDTH=4, wrapping to the terminal value 15).
- len is snapshotted at grant; changes to len during RUN are ignored.
- Changes to non-owner req bits during RUN are ignored. They are considered at the next IDLE.
- A requester must drop req within one cycle of seeing done. If req is still high in IDLE, it re-enters arbitration at the lowest priority, because ptr has advanced past it.
- owner holds its value after completion until the next grant.

## Timing
- Let E0 be the edge at which IDLE samples a request.
  - After E0: gnt and busy are high and cnt=0.
  - After E0+k: cnt=k, for k < len_q.
  - After E0+len_q: state is DONE, gnt=0, done=1, cnt=0, busy=1.
  - After E0+len_q+1: state is IDLE, done=0, busy=0.
  - The earliest next grant is visible after E0+len_q+2.
- Request-to-grant latency is 1 edge. Completion-to-next-grant turnaround is 2 edges.
- gnt is high for exactly len_q cycles (2**WIDTH if len_q=0). done is high for exactly 1 cycle.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- **Reset:** hold rstn=0 for 3 edges with req=4'b1111 → gnt=0, done=0, busy=0, cnt=0, owner=0.
- **Single request:** req=4'b0100, len[2]=3 → gnt=4'b0100 for 3 cycles with cnt 0,1,2, then done=4'b0100 for 1 cycle, then busy=0.
- **Round-robin:** req=4'b1111 held, len=1 for all requesters, each requester drops req the cycle after its done → grants follow the order 0,1,2,3 with owner 0,1,2,3. No requester is granted twice before all others.
- **Wrap length:** len[1]=0, req=4'b0010 → cnt runs 0..15 (16 gnt cycles), then done[1] pulses.
- **Abort and reset mid-run:**
  - Case 1: req[0] dropped when cnt=2 with len_q=5 → gnt=0 on the next edge, no done pulse, the next grant goes to requester 1 if it is pending.
  - Case 2: rstn=0 during RUN → all outputs return to their reset values with no done pulse.
- **Length snapshot:** len[3] changed from 4 to 9 during RUN → the interval still ends after 4 cycles.
